apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB4 initiator driving the 16-bit-data, 20-bit-address, two-target APB bus that the `apb_icn` interconnect responds on. Accepts one command at a time over a valid/ready request port, runs the SETUP/ACCESS sequence, waits for `pready_icn`, and returns read data and error status over a valid/ready response port. A programmable timeout keeps the master from hanging on a responder that never completes.

## Interface
Parameters:
- ADDR_W, 20, APB address width
- DATA_W, 16, APB data width
- STRB_W, 2, write strobe width (DATA_W/8)
- TIMEOUT_CYCLES, 64, max ACCESS cycles before abort; 0 disables timeout

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  STRB_W  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_slverr  out  1  pslverr_icn sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel  out  2  one-hot target select
- penable  out  1  APB enable
- paddr  out  ADDR_W
- pwdata  out  DATA_W
- pwrite  out  1
- pstrb  out  STRB_W
- prdata_icn  in  DATA_W
- pready_icn  in  1
- pslverr_icn  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata/strb, go to SETUP.
- SETUP (one cycle): psel one-hot asserted, penable=0, address/control/data driven from latch. Go to ACCESS.
- ACCESS: psel held, penable=1, all APB outputs stable. On pready_icn=1, capture prdata_icn (reads only, else 0) and pslverr_icn, go to RESP.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready_icn=0. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), abort: go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. Counter width clog2(TIMEOUT_CYCLES+1). If pready_icn=1 on the abort cycle, pready wins: normal completion.
- RESP: rsp_valid=1, outputs held stable until rsp_ready=1, then back to IDLE. psel=0, penable=0.
- psel decode: psel=2'b01 when addr[ADDR_W-1]=0, 2'b10 when 1. Never both; 2'b00 outside SETUP/ACCESS.
- Reads: pwrite=0, pstrb=0, pwdata=0. Writes: pstrb=cmd_strb as latched.
- cmd_ready is 0 in every state but IDLE; cmd inputs are ignored outside IDLE.
- reset asserted mid-transfer: immediately abandons the transfer, all outputs to reset values, state IDLE; no response is produced.

## Timing
- Reset values: cmd_ready=0 while reset is high and 1 in IDLE after release. rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, psel=0, penable=0, paddr=0, pwdata=0, pwrite=0, pstrb=0.
- All outputs registered (cmd_ready decoded from state register only).
- Zero-wait transfer: cmd accept at edge N, SETUP in cycle N+1, ACCESS in N+2 with pready=1, rsp_valid in N+3. Minimum command-to-command spacing is 4 cycles with rsp_ready held high.
- Each ACCESS cycle with pready_icn=0 adds one cycle. Timeout asserts rsp_valid TIMEOUT_CYCLES+1 cycles after ACCESS entry.
- pready_icn, prdata_icn and pslverr_icn are sampled only in ACCESS. Values in other states are ignored, including random toggling.

## Structure
- Package `apb_pkg`: state enum (IDLE/SETUP/ACCESS/RESP), default ADDR_W/DATA_W/STRB_W constants, and the psel decode function. Shared with the interconnect and its bench.
- Single module; no sub-module needed. The timeout counter stays inline.

## Test plan
- Zero-wait read: responder pready=1, prdata=16'hABCD, addr=20'h00010 → psel=01 for 2 cycles, rsp_rdata=16'hABCD, slverr=0, rsp_valid at N+3.
- Write with 3 wait states to addr=20'h80004, wdata=16'h1234, strb=2'b10 → psel=10, pstrb=10, APB outputs stable for 4 ACCESS cycles, rsp_rdata=0.
- Error: pready=1 with pslverr=1 on a write → rsp_slverr=1, rsp_timeout=0; responder with random pready/pslverr over 200 transfers matches the scoreboard.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 → abort after 8 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, psel drops.
- Backpressure: rsp_ready=0 for 5 cycles → response held stable, cmd_ready=0, a second cmd_valid is not accepted until after the handshake.
- Reset asserted during ACCESS → all outputs return to 0 asynchronously, no rsp_valid. After release, the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the master bridge, the interconnect and their benches.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 20;
  localparam int unsigned APB_DATA_W = 16;
  localparam int unsigned APB_STRB_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  // Two-target decode: the address MSB picks the target, result is one-hot.
  function automatic logic [1:0] psel_decode(input logic addr_msb);
    return addr_msb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// APB4 initiator: one command at a time in, SETUP/ACCESS on the bus,
// one response out, with an optional ACCESS-phase timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned STRB_W         = APB_STRB_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [1:0]        psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] prdata_icn,
  input  logic              pready_icn,
  input  logic              pslverr_icn
);

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_t       state;
  apb_state_t       state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             access_done;
  logic             access_abort;

  // Next-state decode; pready takes priority over the timeout on the same cycle.
  always_comb begin
    state_next   = state;
    access_done  = 1'b0;
    access_abort = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready_icn) begin
          access_done = 1'b1;
          state_next  = RESP;
        end else if (TIMEOUT_EN && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
          access_abort = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; cmd_ready is registered from the next state so it stays low during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
    end
  end

  // Registered APB drive, timeout counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psel        <= '0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      pstrb       <= '0;
      tmo_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            psel   <= psel_decode(cmd_addr[ADDR_W-1]);
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
            pstrb  <= cmd_write ? cmd_strb : '0;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= '0;
        end
        ACCESS: begin
          if (access_done || access_abort) begin
            psel        <= '0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            pstrb       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (access_done && !pwrite) ? prdata_icn : '0;
            rsp_slverr  <= access_done ? pslverr_icn : 1'b1;
            rsp_timeout <= access_abort;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [1:0]  psel;
  logic        penable;
  logic [19:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic [1:0]  pstrb;
  logic [15:0] prdata_icn = '0;
  logic        pready_icn = 1'b0;
  logic        pslverr_icn = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_master_bridge #(
    .ADDR_W(20),
    .DATA_W(16),
    .STRB_W(2),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb),
    .prdata_icn(prdata_icn), .pready_icn(pready_icn), .pslverr_icn(pslverr_icn)
  );

  // Every output flattened; all zero in reset.
  function automatic logic [61:0] all_outs();
    return {cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
            psel, penable, paddr, pwdata, pwrite, pstrb};
  endfunction

  // One complete transaction against the model: responder inserts wait_n stall cycles,
  // consumer holds off bp cycles, junk toggles ignored inputs.
  task automatic xfer(input logic wr, input logic [19:0] addr, input logic [15:0] wd,
                      input logic [1:0] st, input int unsigned wait_n, input logic err,
                      input logic [15:0] rd, input int unsigned bp, input bit junk,
                      output int unsigned acc_cyc);
    logic [1:0]  e_psel;
    logic [41:0] e_apb, o_apb;
    logic [18:0] e_rsp, o_rsp;
    bit          tmo;
    int unsigned n;
    acc_cyc = 0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    rsp_ready = 1'b0;
    acc_cyc = cyc;
    e_psel = addr[19] ? 2'b10 : 2'b01;
    tmo = (wait_n > T);

    @(negedge clk);
    e_apb = {e_psel, 1'b0, addr, wr, wr ? wd : 16'h0, wr ? st : 2'b00};
    o_apb = {psel, penable, paddr, pwrite, pwdata, pstrb};
    checks++;
    if (o_apb !== e_apb) begin
      errors++;
      $display("FAIL setup_apb: got %h expected %h", o_apb, e_apb);
    end
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL setup_hs: got %b expected 00", {cmd_ready, rsp_valid});
    end
    cmd_valid = junk ? 1'($urandom) : 1'b0;
    if (junk) begin
      cmd_write = 1'($urandom); cmd_addr = 20'($urandom);
      cmd_wdata = 16'($urandom); cmd_strb = 2'($urandom);
    end
    pready_icn = 1'($urandom); prdata_icn = 16'($urandom); pslverr_icn = 1'($urandom);

    e_apb = {e_psel, 1'b1, addr, wr, wr ? wd : 16'h0, wr ? st : 2'b00};
    for (int k = 0; k <= int'(T); k++) begin
      @(negedge clk);
      o_apb = {psel, penable, paddr, pwrite, pwdata, pstrb};
      checks++;
      if (o_apb !== e_apb) begin
        errors++;
        $display("FAIL access_apb[%0d]: got %h expected %h", k, o_apb, e_apb);
      end
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL access_hs[%0d]: got %b expected 00", k, {cmd_ready, rsp_valid});
      end
      if (k == int'(wait_n)) begin
        pready_icn = 1'b1; prdata_icn = rd; pslverr_icn = err;
        break;
      end
      pready_icn = 1'b0; prdata_icn = 16'($urandom); pslverr_icn = 1'($urandom);
    end

    e_rsp = {1'b1, (tmo || wr) ? 16'h0 : rd, tmo ? 1'b1 : err, tmo};
    for (int r = 0; r <= int'(bp); r++) begin
      @(negedge clk);
      o_rsp = {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout};
      checks++;
      if (o_rsp !== e_rsp) begin
        errors++;
        $display("FAIL rsp[%0d]: got %h expected %h", r, o_rsp, e_rsp);
      end
      checks++;
      if ({psel, penable, cmd_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL rsp_bus[%0d]: got %b expected 0000", r, {psel, penable, cmd_ready});
      end
      rsp_ready = (r == int'(bp));
      cmd_valid = junk ? 1'($urandom) : 1'b0;
      pready_icn = 1'($urandom); prdata_icn = 16'($urandom); pslverr_icn = 1'($urandom);
    end

    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, psel} !== 4'b0100) begin
      errors++;
      $display("FAIL post_hs: got %b expected 0100", {rsp_valid, cmd_ready, psel});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [61:0] o;
    reset = 1'b1;
    #1;
    o = all_outs();
    checks++;
    if (o !== 62'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", o);
    end
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    o = all_outs();
    checks++;
    if (o !== 62'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", o);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    o = all_outs();
    checks++;
    if (o !== {1'b1, 61'h0}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", o, {1'b1, 61'h0});
    end
  endtask

  task automatic test_zero_wait_read();
    int unsigned a;
    xfer(1'b0, 20'h00010, 16'h5555, 2'b11, 0, 1'b0, 16'hABCD, 0, 1'b0, a);
  endtask

  task automatic test_wait_write();
    int unsigned a;
    xfer(1'b1, 20'h80004, 16'h1234, 2'b10, 3, 1'b0, 16'hFFFF, 0, 1'b0, a);
  endtask

  task automatic test_slverr();
    int unsigned a;
    xfer(1'b1, 20'h00222, 16'hBEEF, 2'b01, 0, 1'b1, 16'h0F0F, 0, 1'b0, a);
    xfer(1'b0, 20'h90000, 16'h0, 2'b00, 2, 1'b1, 16'h7E57, 1, 1'b0, a);
  endtask

  task automatic test_timeout();
    int unsigned a;
    xfer(1'b0, 20'h00400, 16'h0, 2'b00, 1000, 1'b0, 16'h1111, 0, 1'b0, a);
    xfer(1'b0, 20'h80400, 16'h0, 2'b00, T, 1'b1, 16'h2222, 0, 1'b0, a);
    xfer(1'b1, 20'h80400, 16'h3333, 2'b11, T + 1, 1'b0, 16'h4444, 0, 1'b0, a);
  endtask

  task automatic test_backpressure();
    int unsigned a;
    xfer(1'b0, 20'h0C0DE, 16'h0, 2'b00, 1, 1'b0, 16'hC0DE, 5, 1'b1, a);
  endtask

  task automatic test_back_to_back();
    int unsigned a0, a1;
    xfer(1'b0, 20'h00001, 16'h0, 2'b00, 0, 1'b0, 16'h0101, 0, 1'b0, a0);
    xfer(1'b1, 20'h80002, 16'h0202, 2'b11, 0, 1'b0, 16'h0, 0, 1'b0, a1);
    checks++;
    if (a1 - a0 !== 32'd4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 4", a1 - a0);
    end
  endtask

  task automatic test_reset_mid();
    logic [61:0] o;
    int unsigned a;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h8ABCD;
    @(negedge clk);
    cmd_valid = 1'b0; pready_icn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (penable !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_access: got %b expected 1", penable);
    end
    #2 reset = 1'b1;
    #1;
    o = all_outs();
    checks++;
    if (o !== 62'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected 0", o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== 62'h0) begin
      errors++;
      $display("FAIL mid_reset_held: got %h expected 0", all_outs());
    end
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_no_rsp: got %b expected 01", {rsp_valid, cmd_ready});
    end
    rsp_ready = 1'b0;
    xfer(1'b0, 20'h0BEEF, 16'h0, 2'b00, 1, 1'b0, 16'hFACE, 0, 1'b0, a);
  endtask

  task automatic test_random();
    int unsigned a, w;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 6) w = $urandom_range(0, 3);
      else w = $urandom_range(4, T + 3);
      xfer(1'($urandom), 20'($urandom), 16'($urandom), 2'($urandom), w,
           1'($urandom), 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), a);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
